// File: rtl/reg_arb_pkg.sv
// ---------------------------------------------------------------------------
// reg_arb_pkg
// Shared definitions for the register write arbiters:
//   - clog2()        : ceiling log2 helper usable in parameter expressions
//   - REG_ARB_ID_W() : width of a requester/register index, never below 1
//   - txn_e          : transaction type encoding (write / clear)
// ---------------------------------------------------------------------------
package reg_arb_pkg;

  // Transaction type carried on req_clr_i
  typedef enum logic {
    TXN_WRITE = 1'b0,
    TXN_CLEAR = 1'b1
  } txn_e;

  // Ceiling log2; clog2(1) = 0
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  // Index width for N items, at least one bit
  function automatic int unsigned REG_ARB_ID_W(input int unsigned n);
    return (clog2(n) == 0) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational round-robin pick: returns the first set bit of valid_i at or
// above ptr_i, wrapping modulo N.
//   valid_i  [N]    : request vector
//   ptr_i    [ID_W] : search start index (must be < N)
//   gnt_o    [N]    : one-hot grant, all 0 when nothing is valid
//   gnt_id_o [ID_W] : index of the granted bit (0 when nothing is valid)
//   any_o           : a grant was issued
// ---------------------------------------------------------------------------
module rr_picker #(
  parameter int unsigned N    = 4,
  parameter int unsigned ID_W = 2
) (
  input  logic [N-1:0]    valid_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [ID_W-1:0] gnt_id_o,
  output logic            any_o
);

  int unsigned ptr_u;
  logic        found;

  // Two passes: indices at/above the pointer first, then the wrapped ones
  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    found    = 1'b0;
    ptr_u    = 32'(ptr_i);
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && (i >= ptr_u) && valid_i[i]) begin
        found    = 1'b1;
        gnt_o[i] = 1'b1;
        gnt_id_o = ID_W'(i);
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && (i < ptr_u) && valid_i[i]) begin
        found    = 1'b1;
        gnt_o[i] = 1'b1;
        gnt_id_o = ID_W'(i);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// ---------------------------------------------------------------------------
// reg_write_arbiter
// Round-robin write/clear arbiter in front of a bank of MyReg registers.
// One transaction is accepted per cycle; its strobes appear registered on the
// bank outputs the following cycle.
//   clk_i, en_i, rst_i    : clock, clock enable, synchronous active-high reset
//   req_valid_i [N_REQ]   : per-requester valid
//   req_clr_i   [N_REQ]   : 1 = clear, 0 = write
//   req_addr_i  [N_REQ*ADDR_W], req_data_i [N_REQ*DATA_W] : packed per requester
//   req_ready_o [N_REQ]   : combinational one-hot grant
//   reg_e_o / reg_r_o [N_REGS] : one-hot write / clear strobes
//   reg_n_o [DATA_W]      : shared write data (0 for clears)
//   grant_id_o            : requester that owns the current bank outputs
//   err_o                 : one-cycle pulse for an out-of-range address
// Optional macro REG_ARB_LOCK_EN adds req_lock_i [N_REQ]: an accepted
// transaction with lock=1 pins arbitration to that requester until it has a
// transaction accepted with lock=0.
// ---------------------------------------------------------------------------
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter  int unsigned N_REQ  = 4,
  parameter  int unsigned N_REGS = 8,
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned ADDR_W = REG_ARB_ID_W(N_REGS),
  localparam int unsigned ID_W   = REG_ARB_ID_W(N_REQ)
) (
  input  logic                     clk_i,
  input  logic                     en_i,
  input  logic                     rst_i,
  input  logic [N_REQ-1:0]         req_valid_i,
  input  logic [N_REQ-1:0]         req_clr_i,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr_i,
  input  logic [N_REQ*DATA_W-1:0]  req_data_i,
  output logic [N_REQ-1:0]         req_ready_o,
  output logic [N_REGS-1:0]        reg_e_o,
  output logic [N_REGS-1:0]        reg_r_o,
  output logic [DATA_W-1:0]        reg_n_o,
  output logic [ID_W-1:0]          grant_id_o,
  output logic                     err_o
`ifdef REG_ARB_LOCK_EN
  ,
  input  logic [N_REQ-1:0]         req_lock_i
`endif
);

  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [N_REQ-1:0]  pick_valid;
  logic [N_REQ-1:0]  gnt;
  logic [ID_W-1:0]   gnt_id;
  logic              gnt_any;
  logic [ID_W-1:0]   ptr_next;

  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              sel_clr;
  txn_e              sel_type;
  logic              addr_ok;

  logic [N_REGS-1:0] reg_e_q, reg_e_d;
  logic [N_REGS-1:0] reg_r_q, reg_r_d;
  logic [DATA_W-1:0] reg_n_q, reg_n_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic              err_q, err_d;

`ifdef REG_ARB_LOCK_EN
  logic lock_q, lock_d;
  logic sel_lock;
`endif

  // Requests seen by the picker: none while disabled or in reset; only the
  // owner while a lock is held (ptr_q sits on the owner)
  always_comb begin
    pick_valid = '0;
    if (en_i && !rst_i) begin
`ifdef REG_ARB_LOCK_EN
      if (lock_q) pick_valid = req_valid_i & (N_REQ'(1) << ptr_q);
      else        pick_valid = req_valid_i;
`else
      pick_valid = req_valid_i;
`endif
    end
  end

  rr_picker #(
    .N    (N_REQ),
    .ID_W (ID_W)
  ) u_picker (
    .valid_i  (pick_valid),
    .ptr_i    (ptr_q),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id),
    .any_o    (gnt_any)
  );

  assign req_ready_o = gnt;

  // Select the granted requester's payload
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_clr  = 1'b0;
`ifdef REG_ARB_LOCK_EN
    sel_lock = 1'b0;
`endif
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        sel_addr = req_addr_i[i*ADDR_W +: ADDR_W];
        sel_data = req_data_i[i*DATA_W +: DATA_W];
        sel_clr  = req_clr_i[i];
`ifdef REG_ARB_LOCK_EN
        sel_lock = req_lock_i[i];
`endif
      end
    end
    sel_type = sel_clr ? TXN_CLEAR : TXN_WRITE;
    addr_ok  = (32'(sel_addr) < N_REGS);
  end

  // Pointer (and lock) update on acceptance; holds otherwise
  always_comb begin
    ptr_next = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
    ptr_d    = ptr_q;
`ifdef REG_ARB_LOCK_EN
    lock_d   = lock_q;
    if (gnt_any) begin
      if (sel_lock) begin
        ptr_d  = gnt_id;
        lock_d = 1'b1;
      end else begin
        ptr_d  = ptr_next;
        lock_d = 1'b0;
      end
    end
`else
    if (gnt_any) ptr_d = ptr_next;
`endif
  end

  // Execute stage: strobes are single-cycle, everything holds while disabled
  always_comb begin
    reg_e_d    = '0;
    reg_r_d    = '0;
    err_d      = 1'b0;
    reg_n_d    = reg_n_q;
    grant_id_d = grant_id_q;
    if (!en_i) begin
      reg_e_d = reg_e_q;
      reg_r_d = reg_r_q;
      err_d   = err_q;
    end else if (gnt_any) begin
      grant_id_d = gnt_id;
      if (!addr_ok) begin
        err_d   = 1'b1;
        reg_n_d = '0;
      end else if (sel_type == TXN_CLEAR) begin
        reg_n_d = '0;
        for (int unsigned r = 0; r < N_REGS; r++) begin
          if (sel_addr == ADDR_W'(r)) reg_r_d[r] = 1'b1;
        end
      end else begin
        reg_n_d = sel_data;
        for (int unsigned r = 0; r < N_REGS; r++) begin
          if (sel_addr == ADDR_W'(r)) reg_e_d[r] = 1'b1;
        end
      end
    end
  end

  // State registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q      <= '0;
      reg_e_q    <= '0;
      reg_r_q    <= '0;
      reg_n_q    <= '0;
      grant_id_q <= '0;
      err_q      <= 1'b0;
`ifdef REG_ARB_LOCK_EN
      lock_q     <= 1'b0;
`endif
    end else begin
      ptr_q      <= ptr_d;
      reg_e_q    <= reg_e_d;
      reg_r_q    <= reg_r_d;
      reg_n_q    <= reg_n_d;
      grant_id_q <= grant_id_d;
      err_q      <= err_d;
`ifdef REG_ARB_LOCK_EN
      lock_q     <= lock_d;
`endif
    end
  end

  assign reg_e_o    = reg_e_q;
  assign reg_r_o    = reg_r_q;
  assign reg_n_o    = reg_n_q;
  assign grant_id_o = grant_id_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter with N_REQ=4, N_REGS=6, DATA_W=32.
module tb_reg_write_arbiter;

  localparam logic [11:0]  FA = {3'd5, 3'd4, 3'd3, 3'd2};
  localparam logic [127:0] FD = {32'h3D3D0004, 32'h2C2C0003, 32'h1B1B0002, 32'h0A0A0001};

  logic         clk = 1'b0;
  logic         en, rst;
  logic [3:0]   valid, clr;
  logic [11:0]  addr;
  logic [127:0] data;
  logic [3:0]   ready;
  logic [5:0]   e, r;
  logic [31:0]  n;
  logic [1:0]   gid;
  logic         err;
`ifdef REG_ARB_LOCK_EN
  logic [3:0]   lock;
`endif

  always #5 clk = ~clk;

  reg_write_arbiter #(
    .N_REQ  (4),
    .N_REGS (6),
    .DATA_W (32)
  ) dut (
    .clk_i       (clk),
    .en_i        (en),
    .rst_i       (rst),
    .req_valid_i (valid),
    .req_clr_i   (clr),
    .req_addr_i  (addr),
    .req_data_i  (data),
    .req_ready_o (ready),
    .reg_e_o     (e),
    .reg_r_o     (r),
    .reg_n_o     (n),
    .grant_id_o  (gid),
    .err_o       (err)
`ifdef REG_ARB_LOCK_EN
    ,
    .req_lock_i  (lock)
`endif
  );

  // Behavioural stand-in for the MyReg bank (reset value 0)
  logic [31:0] bank_q [6];
  always @(posedge clk) begin
    for (int k = 0; k < 6; k++) begin
      if (rst)        bank_q[k] <= '0;
      else if (en) begin
        if (r[k])      bank_q[k] <= '0;
        else if (e[k]) bank_q[k] <= n;
      end
    end
  end

  typedef struct {
    logic [3:0]   valid;
    logic [3:0]   clr;
    logic [11:0]  addr;
    logic [127:0] data;
    logic [3:0]   ready;
    logic [5:0]   e;
    logic [5:0]   r;
    logic [31:0]  n;
    logic [1:0]   id;
    logic         err;
    bit           chk_n;
    bit           chk_id;
  } vec_t;

  typedef struct {
    int          idx;
    logic [5:0]  e;
    logic [5:0]  r;
    logic [31:0] n;
    logic [1:0]  id;
    logic        err;
    bit          chk_n;
    bit          chk_id;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  function automatic vec_t mk(logic [3:0] v, logic [3:0] c, logic [11:0] a,
                              logic [127:0] d, logic [3:0] rdy, logic [5:0] xe,
                              logic [5:0] xr, logic [31:0] xn, logic [1:0] xid,
                              logic xerr, bit cn, bit ci);
    vec_t t;
    t.valid = v;   t.clr = c;   t.addr = a;  t.data = d;
    t.ready = rdy; t.e = xe;    t.r = xr;    t.n = xn;
    t.id = xid;    t.err = xerr; t.chk_n = cn; t.chk_id = ci;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_exp(input exp_t x);
    chk($sformatf("v%0d reg_e", x.idx), 32'(e), 32'(x.e));
    chk($sformatf("v%0d reg_r", x.idx), 32'(r), 32'(x.r));
    chk($sformatf("v%0d err", x.idx), 32'(err), 32'(x.err));
    if (x.chk_n)  chk($sformatf("v%0d reg_n", x.idx), n, x.n);
    if (x.chk_id) chk($sformatf("v%0d grant_id", x.idx), 32'(gid), 32'(x.id));
  endtask

  task automatic check_zero(input string nm);
    chk({nm, " reg_e"}, 32'(e), 32'd0);
    chk({nm, " reg_r"}, 32'(r), 32'd0);
    chk({nm, " reg_n"}, n, 32'd0);
    chk({nm, " grant_id"}, 32'(gid), 32'd0);
    chk({nm, " err"}, 32'(err), 32'd0);
  endtask

  initial begin
    logic [31:0] bank_exp [6];
    exp_t x;

    // Vector table; pointer starts at 0 after reset
    vecs.push_back(mk('0, '0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 0, 0));
    for (int k = 0; k < 8; k++) begin
      vecs.push_back(mk(4'hF, '0, FA, FD, 4'(1 << (k % 4)), 6'(4 << (k % 4)), '0,
                        FD[(k % 4)*32 +: 32], 2'(k % 4), 1'b0, 1, 1));
    end
    vecs.push_back(mk(4'b0010, '0, {3'd0, 3'd0, 3'd3, 3'd0},
                      {32'h0, 32'h0, 32'hDEADBEEF, 32'h0},
                      4'b0010, 6'h08, '0, 32'hDEADBEEF, 2'd1, 1'b0, 1, 1));
    vecs.push_back(mk('0, '0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 0, 0));
    vecs.push_back(mk(4'b0100, 4'b0100, {3'd0, 3'd5, 3'd0, 3'd0},
                      {32'h0, 32'hFFFFFFFF, 64'h0},
                      4'b0100, '0, 6'h20, 32'h0, 2'd2, 1'b0, 1, 1));
    vecs.push_back(mk(4'b0001, '0, {9'd0, 3'd7}, {96'h0, 32'h55555555},
                      4'b0001, '0, '0, '0, 2'd0, 1'b1, 0, 1));
    vecs.push_back(mk('0, '0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 0, 0));
    vecs.push_back(mk(4'b0010, '0, {3'd0, 3'd0, 3'd6, 3'd0},
                      {64'h0, 32'h66666666, 32'h0},
                      4'b0010, '0, '0, '0, 2'd1, 1'b1, 0, 1));
    vecs.push_back(mk(4'b1001, '0, {3'd0, 3'd0, 3'd0, 3'd1},
                      {32'h77770000, 64'h0, 32'h88880001},
                      4'b1000, 6'h01, '0, 32'h77770000, 2'd3, 1'b0, 1, 1));
    vecs.push_back(mk(4'b1001, '0, {3'd0, 3'd0, 3'd0, 3'd1},
                      {32'h77770000, 64'h0, 32'h88880001},
                      4'b0001, 6'h02, '0, 32'h88880001, 2'd0, 1'b0, 1, 1));
    vecs.push_back(mk('0, '0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 0, 0));

    // Reset with requests pending: no grant, outputs 0
    en = 1'b1; rst = 1'b1; valid = 4'hF; clr = '0; addr = FA; data = FD;
`ifdef REG_ARB_LOCK_EN
    lock = '0;
`endif
    #1 chk("reset ready", 32'(ready), 32'd0);
    tick();
    tick();
    chk("reset ready2", 32'(ready), 32'd0);
    check_zero("reset");
    rst = 1'b0; valid = '0;
    for (int c = 0; c < 10; c++) begin
      #1 chk($sformatf("idle%0d ready", c), 32'(ready), 32'd0);
      tick();
    end

    // Table-driven stream with scoreboard of next-cycle bank outputs
    for (int i = 0; i < vecs.size(); i++) begin
      tick();
      if (sb.size() > 0) check_exp(sb.pop_front());
      valid = vecs[i].valid; clr = vecs[i].clr;
      addr  = vecs[i].addr;  data = vecs[i].data;
      #1 chk($sformatf("v%0d ready", i), 32'(ready), 32'(vecs[i].ready));
      x.idx = i; x.e = vecs[i].e; x.r = vecs[i].r; x.n = vecs[i].n;
      x.id = vecs[i].id; x.err = vecs[i].err;
      x.chk_n = vecs[i].chk_n; x.chk_id = vecs[i].chk_id;
      sb.push_back(x);
    end
    tick();
    if (sb.size() > 0) check_exp(sb.pop_front());
    valid = '0; clr = '0;
    bank_exp[0] = 32'h77770000; bank_exp[1] = 32'h88880001;
    bank_exp[2] = 32'h0A0A0001; bank_exp[3] = 32'hDEADBEEF;
    bank_exp[4] = 32'h2C2C0003; bank_exp[5] = 32'h0;
    for (int k = 0; k < 6; k++) chk($sformatf("bank[%0d]", k), bank_q[k], bank_exp[k]);

    // Enable low for 3 cycles mid-stream (pointer at 1)
    valid = 4'b0100; addr = {3'd0, 3'd4, 3'd0, 3'd0}; data = {32'h0, 32'h44444444, 64'h0};
    #1 chk("en pre ready", 32'(ready), 32'b0100);
    tick();
    chk("en strobe e", 32'(e), 32'h10);
    chk("en strobe n", n, 32'h44444444);
    en = 1'b0; valid = 4'hF; addr = FA; data = FD;
    #1 chk("en0 ready", 32'(ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("en0 c%0d e", c), 32'(e), 32'h10);
      chk($sformatf("en0 c%0d n", c), n, 32'h44444444);
      chk($sformatf("en0 c%0d id", c), 32'(gid), 32'd2);
      chk($sformatf("en0 c%0d ready", c), 32'(ready), 32'd0);
    end
    en = 1'b1;
    #1 chk("en1 ready", 32'(ready), 32'b1000);
    tick();
    chk("en1 e", 32'(e), 32'h20);
    chk("en1 n", n, 32'h3D3D0004);
    chk("en1 id", 32'(gid), 32'd3);

    // Reset the cycle after an acceptance; pointer must return to 0
    valid = 4'b0001;
    #1 chk("pre-rst ready", 32'(ready), 32'b0001);
    tick();
    rst = 1'b1; valid = 4'hF;
    #1 chk("rst ready", 32'(ready), 32'd0);
    tick();
    check_zero("rst mid");
    rst = 1'b0;
    #1 chk("post-rst ready", 32'(ready), 32'b0001);
    tick();
    valid = '0;

`ifdef REG_ARB_LOCK_EN
    // Pointer 1: req1 first moves it to 2, then req2 locks
    valid = 4'b0010;
    #1 chk("lk pre ready", 32'(ready), 32'b0010);
    tick();
    valid = 4'b1101; lock = 4'b0100;
    #1 chk("lk take", 32'(ready), 32'b0100);
    for (int c = 0; c < 2; c++) begin
      tick();
      #1 chk($sformatf("lk hold%0d", c), 32'(ready), 32'b0100);
    end
    tick();
    valid = 4'b1001;
    #1 chk("lk owner idle", 32'(ready), 32'd0);
    tick();
    valid = 4'b1101; lock = 4'b0000;
    #1 chk("lk release", 32'(ready), 32'b0100);
    tick();
    valid = 4'b1001;
    #1 chk("lk next", 32'(ready), 32'b1000);
    tick();
    valid = '0;
`endif

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
